// File: rtl/sky_pkg.sv
// Shared types and constants for the sky renderer: day-cycle phases,
// the colour triple and the star-field LFSR definition.
package sky_pkg;

  typedef enum logic [1:0] {
    DAWN  = 2'd0,
    DAY   = 2'd1,
    DUSK  = 2'd2,
    NIGHT = 2'd3
  } phase_t;

  // Channels are held wide here and cut down to COLOR_BITS at the output.
  localparam int CHAN_W = 8;

  typedef struct packed {
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] b;
  } rgb_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sky_phase_fsm.sv
// Animation state: phase timer, day-cycle phase, frame counter and sun x
// position, all advanced only by an unpaused frame tick.
module sky_phase_fsm
  import sky_pkg::*;
#(
  parameter int FRAMES_PER_PHASE = 64,
  parameter int H_DISPLAY        = 640,
  parameter int SUN_STEP         = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick,
  input  logic       i_pause,
  output phase_t     o_phase,
  output logic [9:0] o_frame_count,
  output logic [9:0] o_sun_x
);

  localparam int TW = (FRAMES_PER_PHASE > 1) ? $clog2(FRAMES_PER_PHASE) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(FRAMES_PER_PHASE - 1);

  logic [TW-1:0] r_timer, w_timer_nxt;
  phase_t        r_phase, w_phase_nxt;
  logic [9:0]    r_frame_count, w_frame_count_nxt;
  logic [9:0]    r_sun_x, w_sun_x_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer       <= '0;
      r_phase       <= DAWN;
      r_frame_count <= '0;
      r_sun_x       <= '0;
    end else begin
      r_timer       <= w_timer_nxt;
      r_phase       <= w_phase_nxt;
      r_frame_count <= w_frame_count_nxt;
      r_sun_x       <= w_sun_x_nxt;
    end
  end

  // Sun stepping looks at the phase before the tick; only NIGHT->DAWN clears it.
  always_comb begin
    w_timer_nxt       = r_timer;
    w_phase_nxt       = r_phase;
    w_frame_count_nxt = r_frame_count;
    w_sun_x_nxt       = r_sun_x;
    if (i_tick && !i_pause) begin
      w_frame_count_nxt = r_frame_count + 10'd1;
      if (r_timer == TIMER_LAST) begin
        w_timer_nxt = '0;
        w_phase_nxt = phase_t'(r_phase + 2'd1);
      end else begin
        w_timer_nxt = r_timer + TW'(1);
      end
      if (r_phase == NIGHT && w_phase_nxt == DAWN) begin
        w_sun_x_nxt = '0;
      end else if (r_phase != NIGHT) begin
        if (({1'b0, r_sun_x} + 11'(SUN_STEP)) >= 11'(H_DISPLAY))
          w_sun_x_nxt = '0;
        else
          w_sun_x_nxt = r_sun_x + 10'(SUN_STEP);
      end
    end
  end

  assign o_phase       = r_phase;
  assign o_frame_count = r_frame_count;
  assign o_sun_x       = r_sun_x;

endmodule

// File: rtl/sky_scene_renderer.sv
// Day/night sky renderer: banded gradient, moving sun, registered RGB/sync.
// Define STARS_EN to add an LFSR star field in the NIGHT phase.
module sky_scene_renderer
  import sky_pkg::*;
#(
  parameter int COLOR_BITS       = 2,
  parameter int BANDS            = 4,
  parameter int H_DISPLAY        = 640,
  parameter int V_DISPLAY        = 480,
  parameter int FRAMES_PER_PHASE = 64,
  parameter int SUN_SIZE         = 32,
  parameter int SUN_STEP         = 2,
  parameter int SUN_Y_LOW        = 352,
  parameter int SUN_Y_HIGH       = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            hpos,
  input  logic [9:0]            vpos,
  input  logic                  display_on,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  pause,
  output logic [COLOR_BITS-1:0] r,
  output logic [COLOR_BITS-1:0] g,
  output logic [COLOR_BITS-1:0] b,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic [1:0]            phase,
  output logic [9:0]            frame_count
);

  localparam int BAND_BITS = $clog2(BANDS);
  localparam logic [COLOR_BITS-1:0] MAX = '1;

  logic                  w_tick;
  phase_t                w_phase;
  logic [9:0]            w_frame_count;
  logic [9:0]            w_sun_x;
  logic [9:0]            w_sun_y;
  logic                  w_sun_hit;
  logic                  w_star;
  logic [BAND_BITS-1:0]  w_band;
  logic [COLOR_BITS-1:0] w_shade;
  rgb_t                  w_pix;

  assign w_tick = (hpos == 10'd0) && (vpos == 10'(V_DISPLAY));

  sky_phase_fsm #(
    .FRAMES_PER_PHASE(FRAMES_PER_PHASE),
    .H_DISPLAY       (H_DISPLAY),
    .SUN_STEP        (SUN_STEP)
  ) u_fsm (
    .clk          (clk),
    .reset        (reset),
    .i_tick       (w_tick),
    .i_pause      (pause),
    .o_phase      (w_phase),
    .o_frame_count(w_frame_count),
    .o_sun_x      (w_sun_x)
  );

  assign phase       = w_phase;
  assign frame_count = w_frame_count;

  assign w_band = vpos[8 -: BAND_BITS];

  generate
    if (BAND_BITS >= COLOR_BITS) begin : g_shade_msb
      assign w_shade = w_band[BAND_BITS-1 -: COLOR_BITS];
    end else begin : g_shade_pad
      assign w_shade = {w_band, {(COLOR_BITS - BAND_BITS){1'b0}}};
    end
  endgenerate

  // Compare in 11 bits so a sun near the right edge clips instead of wrapping.
  assign w_sun_y   = (w_phase == DAY) ? 10'(SUN_Y_HIGH) : 10'(SUN_Y_LOW);
  assign w_sun_hit = (w_phase != NIGHT)
                  && (hpos >= w_sun_x)
                  && ({1'b0, hpos} < ({1'b0, w_sun_x} + 11'(SUN_SIZE)))
                  && (vpos >= w_sun_y)
                  && ({1'b0, vpos} < ({1'b0, w_sun_y} + 11'(SUN_SIZE)));

`ifdef STARS_EN
  logic [15:0] r_lfsr;

  // Reseeding every frame keeps the star field identical frame to frame.
  always_ff @(posedge clk) begin
    if (reset || w_tick)
      r_lfsr <= LFSR_SEED;
    else if (display_on)
      r_lfsr <= lfsr_next(r_lfsr);
  end

  assign w_star = (r_lfsr[7:0] == 8'hFF);
`else
  assign w_star = 1'b0;
`endif

  always_comb begin
    w_pix = '0;
    if (display_on) begin
      if (w_sun_hit) begin
        w_pix.r = CHAN_W'(MAX);
        w_pix.g = CHAN_W'(MAX);
      end else if (w_star && w_phase == NIGHT) begin
        w_pix.r = CHAN_W'(MAX);
        w_pix.g = CHAN_W'(MAX);
        w_pix.b = CHAN_W'(MAX);
      end else begin
        case (w_phase)
          DAY: begin
            w_pix.r = CHAN_W'(w_shade);
            w_pix.g = CHAN_W'(w_shade);
            w_pix.b = CHAN_W'(MAX);
          end
          NIGHT: begin
            w_pix.b = CHAN_W'(w_shade >> 1);
          end
          default: begin
            w_pix.r = CHAN_W'(MAX);
            w_pix.g = CHAN_W'(MAX - w_shade);
            w_pix.b = CHAN_W'(w_shade);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r         <= '0;
      g         <= '0;
      b         <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      r         <= w_pix.r[COLOR_BITS-1:0];
      g         <= w_pix.g[COLOR_BITS-1:0];
      b         <= w_pix.b[COLOR_BITS-1:0];
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
    end
  end

endmodule

// File: tb/tb_sky_scene_renderer.sv
// Directed bench for sky_scene_renderer: two instances share stimulus, one
// with a long phase (rendering/sun tests) and one with FRAMES_PER_PHASE=2.
module tb_sky_scene_renderer;

  localparam int VD = 480;

  logic       clk = 1'b0;
  logic       reset, display_on, hsync_in, vsync_in, pause;
  logic [9:0] hpos, vpos;

  logic [1:0] rA, gA, bA, rB, gB, bB, phA, phB;
  logic       hsA, vsA, hsB, vsB;
  logic [9:0] fcA, fcB;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sky_scene_renderer #(.FRAMES_PER_PHASE(400)) dutA (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pause(pause), .r(rA), .g(gA), .b(bA), .hsync_out(hsA),
    .vsync_out(vsA), .phase(phA), .frame_count(fcA)
  );

  sky_scene_renderer #(.FRAMES_PER_PHASE(2)) dutB (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pause(pause), .r(rB), .g(gB), .b(bB), .hsync_out(hsB),
    .vsync_out(vsB), .phase(phB), .frame_count(fcB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Inputs are driven just after a falling edge; after one rising edge the
  // registered outputs belong to them and are sampled on the next falling edge.
  task automatic applyStimulus(input int h, input int v, input logic de);
    hpos       = 10'(h);
    vpos       = 10'(v);
    display_on = de;
    @(negedge clk);
  endtask

  task automatic doTicks(input int n);
    repeat (n) begin
      applyStimulus(0, VD, 1'b0);
      applyStimulus(1, VD, 1'b0);
    end
  endtask

  task automatic checkPixelA(input string tag, input int h, input int v,
                             input int er, input int eg, input int eb);
    applyStimulus(h, v, 1'b1);
    checkOutput({tag, "_r"}, 32'(rA), 32'(er));
    checkOutput({tag, "_g"}, 32'(gA), 32'(eg));
    checkOutput({tag, "_b"}, 32'(bA), 32'(eb));
  endtask

  task automatic scanStars(output int cnt, output int sig);
    cnt = 0;
    sig = 0;
    for (int v = 0; v < 8; v++) begin
      for (int h = 0; h < 640; h++) begin
        applyStimulus(h, v, 1'b1);
        if (rB == 2'd3 && gB == 2'd3 && bB == 2'd3) begin
          cnt++;
          sig = sig * 31 + v * 640 + h;
        end
      end
    end
  endtask

  int expPh, prevPh, expSun;
  int cnt1, sig1, cnt2, sig2;

  initial begin
    reset = 1'b1; pause = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    hpos = '0; vpos = '0; display_on = 1'b0;
    @(negedge clk);

    hsync_in = 1'b1;
    applyStimulus(300, 384, 1'b1);
    checkOutput("rst_r", 32'(rA), 0);
    checkOutput("rst_b", 32'(bA), 0);
    checkOutput("rst_hs", 32'(hsA), 0);
    checkOutput("rst_phA", 32'(phA), 0);
    checkOutput("rst_fcA", 32'(fcA), 0);
    checkOutput("rst_phB", 32'(phB), 0);
    reset = 1'b0;

    hsync_in = 1'b1; vsync_in = 1'b0;
    applyStimulus(5, 5, 1'b0);
    checkOutput("sync1_hs", 32'(hsA), 1);
    checkOutput("sync1_vs", 32'(vsA), 0);
    hsync_in = 1'b0; vsync_in = 1'b1;
    applyStimulus(6, 5, 1'b0);
    checkOutput("sync2_hs", 32'(hsA), 0);
    checkOutput("sync2_vs", 32'(vsA), 1);
    vsync_in = 1'b0;

    // Phase sequence on the short-phase instance, sun model from the day cycle rules.
    expSun = 0;
    for (int k = 1; k <= 8; k++) begin
      doTicks(1);
      prevPh = ((k - 1) / 2) % 4;
      expPh  = (k / 2) % 4;
      if (prevPh == 3 && expPh == 0) expSun = 0;
      else if (prevPh != 3) expSun += 2;
      checkOutput($sformatf("phB_k%0d", k), 32'(phB), 32'(expPh));
      checkOutput($sformatf("sunB_k%0d", k), 32'(dutB.u_fsm.o_sun_x), 32'(expSun));
      if (k == 6) begin
        applyStimulus(100, 384, 1'b1);
        checkOutput("nightB_r", 32'(rB), 0);
        checkOutput("nightB_b", 32'(bB), 1);
        scanStars(cnt1, sig1);
      end
      if (k == 7) begin
        applyStimulus(100, 384, 1'b1);
        checkOutput("nightB2_b", 32'(bB), 1);
        scanStars(cnt2, sig2);
      end
    end
    checkOutput("fcB_8", 32'(fcB), 8);
`ifdef STARS_EN
    checkOutput("stars_present", 32'(cnt1 > 0), 1);
    checkOutput("stars_cnt", 32'(cnt2), 32'(cnt1));
    checkOutput("stars_sig", 32'(sig2), 32'(sig1));
`else
    checkOutput("stars_none1", 32'(cnt1), 0);
    checkOutput("stars_none2", 32'(cnt2), 0);
`endif

    // Mid-frame reset on the long-phase instance.
    reset = 1'b1; hsync_in = 1'b1;
    applyStimulus(300, 384, 1'b1);
    checkOutput("rst2_r", 32'(rA), 0);
    checkOutput("rst2_hs", 32'(hsA), 0);
    checkOutput("rst2_fcA", 32'(fcA), 0);
    reset = 1'b0; hsync_in = 1'b0;

    doTicks(10);
    checkOutput("sunA_10", 32'(dutA.u_fsm.o_sun_x), 20);
    checkPixelA("sun_dawn", 25, 352, 3, 3, 0);
    checkPixelA("sky_right", 52, 352, 3, 1, 2);
    checkPixelA("sky_left", 19, 352, 3, 1, 2);
    checkPixelA("dawn_b3", 300, 384, 3, 0, 3);
    applyStimulus(300, 384, 1'b0);
    checkOutput("blank_r", 32'(rA), 0);
    checkOutput("blank_g", 32'(gA), 0);
    checkOutput("blank_b", 32'(bA), 0);

    doTicks(309);
    checkOutput("sunA_638", 32'(dutA.u_fsm.o_sun_x), 638);
    doTicks(1);
    checkOutput("sunA_wrap", 32'(dutA.u_fsm.o_sun_x), 0);
    checkOutput("fcA_320", 32'(fcA), 320);

    pause = 1'b1;
    doTicks(3);
    pause = 1'b0;
    checkOutput("pause_fc", 32'(fcA), 320);
    checkOutput("pause_ph", 32'(phA), 0);
    checkOutput("pause_sun", 32'(dutA.u_fsm.o_sun_x), 0);

    doTicks(80);
    checkOutput("phA_day", 32'(phA), 1);
    checkOutput("sunA_day", 32'(dutA.u_fsm.o_sun_x), 160);
    checkOutput("fcA_400", 32'(fcA), 400);
    checkPixelA("day_top", 100, 0, 0, 0, 3);
    checkPixelA("sun_day", 170, 70, 3, 3, 0);
    checkPixelA("day_b2", 170, 352, 2, 2, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
